uart_tx_mmio: RTL and testbench

Memory-mapped serial transmitter on the I/O side of the data-memory decoder, downstream of the RAM/LED/button address map. Memory decodes the UART word address and presents a qualified write strobe plus the 16-bit write data; this block serialises the low byte as an 8N1 frame on `tx`. It returns a status word that Memory muxes onto its read path, so software polls before each write.

---
 rtl/uart_tx_mmio.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 serial transmitter with a polled busy/full status word.
// Optional write buffer in front of the bit engine when UART_TX_FIFO_EN is defined.
module uart_tx_mmio #(
   parameter int unsigned CLK_DIV    = 217,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] in,
   output logic [15:0] out,
   output logic        tx
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BAUD_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [CNT_W-1:0] baud_cnt_r;
   logic [CNT_W-1:0] baud_next_s;
   logic [2:0]       bit_idx_r;
   logic [2:0]       bit_idx_next_s;
   logic [7:0]       shift_r;
   logic [7:0]       shift_next_s;
   logic             tx_r;
   logic             tx_next_s;
   logic [15:0]      out_r;
   logic             busy_next_s;
   logic             baud_last_s;
   logic             push_s;
   logic             start_s;
   logic [7:0]       start_byte_s;
   logic             unused_s;

   assign unused_s    = ^in[15:8];
   assign baud_last_s = (baud_cnt_r == BAUD_LAST);
   assign push_s      = load & (out_r == 16'h0000);

`ifdef UART_TX_FIFO_EN
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W + 1){1'b0}};
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

   logic [7:0]     fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic [PTR_W:0]   count_next_s;
   logic             pop_s;

   // A byte pushed into an empty buffer becomes visible to the FSM one cycle later.
   assign pop_s        = (state_r == ST_IDLE) & (count_r != CNT_ZERO);
   assign start_s      = pop_s;
   assign start_byte_s = fifo_mem_r[rd_ptr_r];

   // Occupancy after this cycle's push/pop; full is judged on the registered flag.
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase
   end

   assign busy_next_s = (count_next_s == CNT_FULL);

   // Buffer storage and wrapping pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_mem_r[i] <= 8'h00;
         end
      end else begin
         count_r <= count_next_s;
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= in[7:0];
            wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? PTR_ZERO : (wr_ptr_r + PTR_ONE);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? PTR_ZERO : (rd_ptr_r + PTR_ONE);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end
`else
   assign start_s      = push_s;
   assign start_byte_s = in[7:0];
   assign busy_next_s  = (state_next_s != ST_IDLE);
`endif

   // Frame sequencing: the baud counter restarts on every state or bit entry.
   always_comb begin
      state_next_s   = state_r;
      baud_next_s    = baud_cnt_r;
      bit_idx_next_s = bit_idx_r;
      shift_next_s   = shift_r;
      case (state_r)
         ST_IDLE: begin
            baud_next_s = BAUD_ZERO;
            if (start_s) begin
               state_next_s   = ST_START;
               shift_next_s   = start_byte_s;
               bit_idx_next_s = 3'd0;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_last_s) begin
               state_next_s   = ST_DATA;
               baud_next_s    = BAUD_ZERO;
               bit_idx_next_s = 3'd0;
            end else begin
               baud_next_s = baud_cnt_r + BAUD_ONE;
            end
         end
         ST_DATA: begin
            if (baud_last_s) begin
               baud_next_s = BAUD_ZERO;
               if (bit_idx_r == 3'd7) begin
                  state_next_s = ST_STOP;
               end else begin
                  bit_idx_next_s = bit_idx_r + 3'd1;
               end
            end else begin
               baud_next_s = baud_cnt_r + BAUD_ONE;
            end
         end
         ST_STOP: begin
            if (baud_last_s) begin
               state_next_s = ST_IDLE;
               baud_next_s  = BAUD_ZERO;
            end else begin
               baud_next_s = baud_cnt_r + BAUD_ONE;
            end
         end
         default: begin
            state_next_s   = ST_IDLE;
            baud_next_s    = BAUD_ZERO;
            bit_idx_next_s = 3'd0;
         end
      endcase
   end

   // Line level for the upcoming cycle, so tx is registered alongside the state.
   always_comb begin
      tx_next_s = 1'b1;
      case (state_next_s)
         ST_IDLE:  tx_next_s = 1'b1;
         ST_START: tx_next_s = 1'b0;
         ST_DATA:  tx_next_s = shift_next_s[bit_idx_next_s];
         ST_STOP:  tx_next_s = 1'b1;
         default:  tx_next_s = 1'b1;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         baud_cnt_r <= BAUD_ZERO;
         bit_idx_r  <= 3'd0;
         shift_r    <= 8'h00;
         tx_r       <= 1'b1;
         out_r      <= 16'h0000;
      end else begin
         state_r    <= state_next_s;
         baud_cnt_r <= baud_next_s;
         bit_idx_r  <= bit_idx_next_s;
         shift_r    <= shift_next_s;
         tx_r       <= tx_next_s;
         out_r      <= busy_next_s ? 16'h0001 : 16'h0000;
      end
   end

   assign tx  = tx_r;
   assign out = out_r;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (default build, CLK_DIV=4): a frame-position
// model predicts tx/out every cycle, and directed literal checks pin the model.
module tb_uart_tx_mmio;

   localparam int DIV   = 4;
   localparam int FRAME = 10 * DIV;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] in;
   logic [15:0] out;
   logic        tx;

   int checks = 0;
   int errors = 0;

   uart_tx_mmio #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .in   (in),
      .out  (out),
      .tx   (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Bit k of an 8N1 frame: start, eight data bits LSB first, stop.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      else if (k <= 8) return b[k-1];
      else return 1'b1;
   endfunction

   bit         m_armed;
   bit         m_active;
   int         m_pos;
   logic [7:0] m_byte;
   int         dut_frames;
   logic       prev_out;

   // Model: a frame is a 10*DIV cycle window opened by a write accepted while idle.
   initial begin : model_and_compare
      logic exp_tx;
      m_armed    = 1'b0;
      m_active   = 1'b0;
      m_pos      = 0;
      m_byte     = 8'h00;
      dut_frames = 0;
      prev_out   = 1'b0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_armed  = 1'b1;
            m_active = 1'b0;
            m_pos    = 0;
         end else if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) m_active = 1'b0;
         end else if (load) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_byte   = in[7:0];
         end
         #1;
         if (m_armed) begin
            exp_tx = m_active ? frame_bit(m_byte, m_pos / DIV) : 1'b1;
            check("tx_cycle", {15'd0, tx}, {15'd0, exp_tx});
            check("out_cycle", out, m_active ? 16'h0001 : 16'h0000);
            if (out == 16'h0001 && prev_out == 1'b0) dut_frames++;
            prev_out = out[0];
         end
      end
   end

   initial begin : stimulus
      logic [9:0] lit;
      int f0;
      reset = 1'b1;
      load  = 1'b0;
      in    = 16'h0000;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // 1: idle after reset
      repeat (20) @(negedge clk);
      check("t1_tx", {15'd0, tx}, 16'h0001);
      check("t1_out", out, 16'h0000);

      // 2: one frame of 0x55, sampled near the start of each bit
      lit = {1'b1, 8'h55, 1'b0};
      f0 = dut_frames;
      load = 1'b1; in = 16'h1255;
      @(negedge clk);
      load = 1'b0; in = 16'h0000;
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         check("t2_bit", {15'd0, tx}, {15'd0, lit[k]});
         check("t2_busy", out, 16'h0001);
         repeat (4) @(negedge clk);
      end
      check("t2_end_tx", {15'd0, tx}, 16'h0001);
      check("t2_end_out", out, 16'h0000);
      check("t2_frames", 16'(dut_frames - f0), 16'd1);

      // 3: write while busy is dropped
      f0 = dut_frames;
      load = 1'b1; in = 16'h0041;
      @(negedge clk);
      load = 1'b0;
      repeat (10) @(negedge clk);
      load = 1'b1; in = 16'h00FF;
      @(negedge clk);
      load = 1'b0; in = 16'h0000;
      repeat (40) @(negedge clk);
      check("t3_tx", {15'd0, tx}, 16'h0001);
      check("t3_out", out, 16'h0000);
      check("t3_frames", 16'(dut_frames - f0), 16'd1);

      // 4: load held for 10 cycles gives one frame
      f0 = dut_frames;
      load = 1'b1; in = 16'h00A5;
      repeat (10) @(negedge clk);
      load = 1'b0; in = 16'h0000;
      repeat (40) @(negedge clk);
      check("t4_frames", 16'(dut_frames - f0), 16'd1);
      check("t4_out", out, 16'h0000);

      // 5: reset during data bit 3 of 0x3C, then a clean 0x0F frame
      load = 1'b1; in = 16'h003C;
      @(negedge clk);
      load = 1'b0; in = 16'h0000;
      repeat (9) @(negedge clk);
      check("t5_bit1", {15'd0, tx}, 16'h0000);
      repeat (8) @(negedge clk);
      check("t5_bit3", {15'd0, tx}, 16'h0001);
      reset = 1'b1;
      @(negedge clk);
      check("t5_rst_tx", {15'd0, tx}, 16'h0001);
      check("t5_rst_out", out, 16'h0000);
      reset = 1'b0;
      f0 = dut_frames;
      load = 1'b1; in = 16'h000F;
      @(negedge clk);
      load = 1'b0; in = 16'h0000;
      @(negedge clk);
      check("t5_start_tx", {15'd0, tx}, 16'h0000);
      check("t5_start_out", out, 16'h0001);
      repeat (45) @(negedge clk);
      check("t5_frames", 16'(dut_frames - f0), 16'd1);

      // 6: load held across a frame end: second write lands in the single IDLE cycle
      f0 = dut_frames;
      load = 1'b1; in = 16'h0096;
      repeat (45) @(negedge clk);
      load = 1'b0; in = 16'h0000;
      repeat (45) @(negedge clk);
      check("t6_frames", 16'(dut_frames - f0), 16'd2);
      check("t6_out", out, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
